// File: rtl/instr_mem_loader.sv
// Streams a program image into instruction memory, zero-fills the tail,
// and keeps the CPU in reset until every word has been written.
module instr_mem_loader #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              s_valid_i,
    input  logic [DATA_W-1:0] s_data_i,
    output logic              s_ready_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    output logic              cpu_rst_n_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              overflow_o,
    output logic [ADDR_W:0]   word_cnt_o
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0] CNT_MAX = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        FILL,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     cnt_q, cnt_d;
    logic                ovf_q, ovf_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                done_q, done_d;
    logic                hs;

    assign s_ready_o   = (state_q == LOAD);
    assign hs          = s_valid_i && s_ready_o;
    assign busy_o      = (state_q == LOAD) || (state_q == FILL);
    assign done_o      = done_q;
    assign cpu_rst_n_o = done_q;
    assign overflow_o  = ovf_q;
    assign word_cnt_o  = cnt_q;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = waddr_q;
    assign mem_data_o  = wdata_q;

    // Register all state and the write port; reset abandons any load.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
        end
    end

    // Next-state and write-port decode; done lags the final write by a cycle.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = LOAD;
                    addr_d  = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            LOAD: begin
                if (hs) begin
                    we_d    = 1'b1;
                    waddr_d = addr_q;
                    wdata_d = s_data_i;
                    if (s_data_i != '0) begin
                        if (cnt_q != CNT_MAX) begin
                            cnt_d = cnt_q + 1'b1;
                        end
                        if (addr_q == LAST) begin
                            state_d = DONE;
                            ovf_d   = 1'b1;
                        end else begin
                            addr_d = addr_q + 1'b1;
                        end
                    end else if (addr_q == LAST) begin
                        state_d = DONE;
                    end else begin
                        state_d = FILL;
                        addr_d  = addr_q + 1'b1;
                    end
                end
            end
            FILL: begin
                we_d    = 1'b1;
                waddr_d = addr_q;
                wdata_d = '0;
                if (addr_q == LAST) begin
                    state_d = DONE;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            DONE: begin
                if (start_i) begin
                    state_d = LOAD;
                    addr_d  = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end else begin
                    done_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader with a write scoreboard.
// Expected writes are queued at handshake time and popped per mem_we_o pulse.
module tb_instr_mem_loader;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          cpu_rst_n;
    logic          busy;
    logic          done;
    logic          overflow;
    logic [AW:0]   word_cnt;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    wr_t exp_q[$];
    int  n_cmp = 0;
    int  n_err = 0;
    int  npulse = 0;
    int  pbase = 0;
    int  exp_addr = 0;
    bit  pend_done = 1'b0;

    instr_mem_loader #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .s_valid_i  (s_valid),
        .s_data_i   (s_data),
        .s_ready_o  (s_ready),
        .mem_we_o   (mem_we),
        .mem_addr_o (mem_addr),
        .mem_data_o (mem_data),
        .cpu_rst_n_o(cpu_rst_n),
        .busy_o     (busy),
        .done_o     (done),
        .overflow_o (overflow),
        .word_cnt_o (word_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: pop one expected write per pulse, check done timing.
    always @(negedge clk) begin
        wr_t e;
        if (pend_done) begin
            check("done_rise", {31'd0, done}, 32'd1);
            check("cpu_release", {31'd0, cpu_rst_n}, 32'd1);
        end
        pend_done = 1'b0;
        check("busy_done_excl", {31'd0, busy & done}, 32'd0);
        check("cpu_held_busy", {31'd0, busy & cpu_rst_n}, 32'd0);
        if (mem_we === 1'b1) begin
            npulse++;
            n_cmp++;
            assert (exp_q.size() != 0) else begin
                n_err++;
                $error("FAIL write_unexpected: addr %0d data %0h, none queued",
                       mem_addr, mem_data);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("wr_addr", {27'd0, mem_addr}, {27'd0, e.a});
                check("wr_data", mem_data, e.d);
            end
            if (mem_addr == AW'(DEPTH - 1)) begin
                check("done_low_at_last", {31'd0, done}, 32'd0);
                pend_done = 1'b1;
            end
        end
    end

    // Offer one word; returns at the negedge after its handshake.
    task automatic send_word(input logic [DW-1:0] w, input bit gap);
        int t;
        t = 0;
        s_valid = 1'b1;
        s_data  = w;
        while (s_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (s_ready !== 1'b1) begin
            check("ready_timeout", {31'd0, s_ready}, 32'd1);
            s_valid = 1'b0;
            return;
        end
        exp_q.push_back(wr_t'{a: AW'(exp_addr), d: w});
        if (w == '0) begin
            for (int k = exp_addr + 1; k < DEPTH; k++) begin
                exp_q.push_back(wr_t'{a: AW'(k), d: '0});
            end
        end
        exp_addr++;
        @(negedge clk);
        if (gap) begin
            s_valid = 1'b0;
            start   = 1'b1;
            @(negedge clk);
            start   = 1'b0;
        end
    endtask

    task automatic start_load();
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        exp_addr = 0;
        pbase    = npulse;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (done !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("done_reached", {31'd0, done}, 32'd1);
        check("queue_drained", exp_q.size(), 32'd0);
        check("pulse_count", npulse - pbase, DEPTH);
    endtask

    task automatic send_prog(input bit gap);
        send_word(32'h2001_0005, gap);
        send_word(32'h2002_0003, gap);
        send_word(32'h0022_1813, gap);
        send_word(32'h0000_0000, gap);
        s_valid = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        repeat (2) @(negedge clk);
        check("rst_ready", {31'd0, s_ready}, 32'd0);
        check("rst_we", {31'd0, mem_we}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_cpu", {31'd0, cpu_rst_n}, 32'd0);
        check("rst_cnt", {26'd0, word_cnt}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic load, valid held high
        start_load();
        send_prog(1'b0);
        wait_done();
        check("s1_cnt", {26'd0, word_cnt}, 32'd3);
        check("s1_ovf", {31'd0, overflow}, 32'd0);

        // Reload from DONE, starts ignored during FILL
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        exp_addr = 0;
        pbase    = npulse;
        check("s6_done", {31'd0, done}, 32'd0);
        check("s6_cpu", {31'd0, cpu_rst_n}, 32'd0);
        check("s6_cnt", {26'd0, word_cnt}, 32'd0);
        check("s6_ready", {31'd0, s_ready}, 32'd1);
        send_prog(1'b0);
        start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        check("s6_fill_busy", {31'd0, busy}, 32'd1);
        check("s6_fill_ready", {31'd0, s_ready}, 32'd0);
        wait_done();
        check("s6_cnt_end", {26'd0, word_cnt}, 32'd3);

        // Gapped stream, start pulses in LOAD ignored
        start_load();
        send_prog(1'b1);
        wait_done();
        check("s2_cnt", {26'd0, word_cnt}, 32'd3);
        check("s2_ovf", {31'd0, overflow}, 32'd0);

        // Overflow: 32 non-zero words
        start_load();
        for (int i = 1; i <= DEPTH; i++) begin
            send_word(DW'(i), 1'b0);
        end
        s_valid = 1'b0;
        wait_done();
        check("s3_ovf", {31'd0, overflow}, 32'd1);
        check("s3_cnt", {26'd0, word_cnt}, 32'd32);

        // Immediate end marker, valid raised with start
        start   = 1'b1;
        s_valid = 1'b1;
        s_data  = '0;
        @(negedge clk);
        start    = 1'b0;
        exp_addr = 0;
        pbase    = npulse;
        check("s4_ovf_clr", {31'd0, overflow}, 32'd0);
        send_word(32'h0, 1'b0);
        s_valid = 1'b0;
        wait_done();
        check("s4_cnt", {26'd0, word_cnt}, 32'd0);
        check("s4_ovf", {31'd0, overflow}, 32'd0);

        // Async reset after two accepted words
        start_load();
        send_word(32'h1111_1111, 1'b0);
        send_word(32'h2222_2222, 1'b0);
        s_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("s5_we", {31'd0, mem_we}, 32'd0);
        check("s5_addr", {27'd0, mem_addr}, 32'd0);
        check("s5_data", mem_data, 32'd0);
        check("s5_ready", {31'd0, s_ready}, 32'd0);
        check("s5_busy", {31'd0, busy}, 32'd0);
        check("s5_done", {31'd0, done}, 32'd0);
        check("s5_cpu", {31'd0, cpu_rst_n}, 32'd0);
        check("s5_cnt", {26'd0, word_cnt}, 32'd0);
        check("s5_pending", exp_q.size(), 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        start_load();
        send_prog(1'b0);
        wait_done();
        check("s5_cnt_end", {26'd0, word_cnt}, 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
- Hardware writer for the CPU instruction memory (Instr_Mem, word-addressed, 32-bit).
- Accepts instruction words over a valid/ready stream and writes them into consecutive word addresses starting at 0.
- Zero-fills the rest of memory after the 32'd0 end-of-program marker.
- Holds the CPU in reset (active-low rst_n) until the image is fully written, then releases it.

Parameters:
ADDR_W, 5, word-address width; memory depth DEPTH = 2**ADDR_W (32 words)
DATA_W, 32, instruction word width

Ports:
clk_i  input  1  system clock, all state on rising edge
rst_i  input  1  asynchronous, active-high reset
start_i  input  1  begin a load; honoured only in IDLE or DONE
s_valid_i  input  1  stream word valid
s_data_i  input  DATA_W  stream instruction word
s_ready_o  output  1  loader accepts a word this cycle
mem_we_o  output  1  instruction-memory write enable, one-cycle pulse per word
mem_addr_o  output  ADDR_W  word address (byte address >> 2)
mem_data_o  output  DATA_W  word to write
cpu_rst_n_o  output  1  CPU reset, active-low; 0 = CPU held in reset
busy_o  output  1  in LOAD or FILL
done_o  output  1  image complete, CPU running
overflow_o  output  1  memory filled with no end marker
word_cnt_o  output  ADDR_W+1  non-zero words accepted in the current load

Behaviour:
- Reset (rst_i=1, async): state IDLE; all outputs 0, including cpu_rst_n_o=0; address and count cleared. Reset mid-LOAD or mid-FILL abandons the load; partial memory contents are not restored.
- Handshake: a transfer occurs when s_valid_i && s_ready_o on a rising edge. s_ready_o is high only in LOAD (decoded from state).
- Write path is registered: a handshake at cycle N produces mem_we_o=1 in cycle N+1, with mem_addr_o=current address and mem_data_o=s_data_i. mem_we_o is low when no write is issued.
- States:
  - IDLE: ready=0, cpu_rst_n_o=0. start_i -> LOAD; address=0, word_cnt=0, overflow cleared.
  - LOAD:
    - Non-zero word accepted: write it, word_cnt+1, address+1.
    - Non-zero word accepted at address DEPTH-1: go to DONE and set overflow_o=1.
    - Word == 0 accepted (end marker): write it; word_cnt unchanged. If address == DEPTH-1, go to DONE. Otherwise go to FILL with fill address = address+1.
  - FILL: ready=0. One zero write per cycle at ascending addresses through DEPTH-1, then DONE. The first fill write occurs the cycle after the marker write. Fill write count = DEPTH-1-marker_addr.
  - DONE: done_o=1, cpu_rst_n_o=1, both registered high starting the cycle after the final mem_we_o pulse. start_i -> LOAD; next cycle done_o=0, cpu_rst_n_o=0, overflow/count cleared, address=0.
- start_i in LOAD or FILL is ignored.
- start_i and s_valid_i together in IDLE/DONE: no word is accepted that cycle (ready is low).
- busy_o = (LOAD || FILL); busy_o and done_o are never both high.
- Every address 0..DEPTH-1 is written exactly once per completed load. Total write pulses = DEPTH.
- word_cnt_o saturates at DEPTH; it is never wrapped.

Test Plan:
1. Basic load. Words 0x20010005, 0x20020003, 0x00221813, then 0x00000000, s_valid_i held high:
   - Writes at addr 0-2 with those values; addr 3 = 0; 28 zero fill writes at addr 4-31.
   - 32 mem_we_o pulses total.
   - word_cnt_o=3, overflow_o=0.
   - done_o and cpu_rst_n_o rise the cycle after the addr-31 write.
2. Gapped stream. Same words with s_valid_i toggling every other cycle:
   - Writes occur only the cycle after each handshake; addresses stay contiguous 0,1,2,3.
   - cpu_rst_n_o stays 0 throughout LOAD.
3. Overflow. 32 non-zero words 0x00000001..0x00000020:
   - Addr k receives k+1; no FILL pulses.
   - overflow_o=1, word_cnt_o=32; done_o rises after the addr-31 write.
4. Immediate end marker. First word 0x00000000:
   - addr 0 written with 0, then 31 fill writes.
   - word_cnt_o=0, overflow_o=0.
5. Reset mid-load. Assert rst_i asynchronously after 2 accepted words:
   - All outputs 0 immediately, cpu_rst_n_o=0, state IDLE.
   - A new start_i load begins writing at addr 0.
6. Reload from DONE. After scenario 1, pulse start_i:
   - Next cycle done_o=0, cpu_rst_n_o=0, word_cnt_o=0, s_ready_o=1.
   - Start pulses during the following FILL are ignored.
